// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan FSM states, active-low segment patterns (a..g = bit6..0) and BCD decode.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001101;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Non-decimal nibbles render as a dark digit rather than a hex glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1 while running, held at zero when cleared;
// tick marks the wrap cycle.
module scan_tick_gen #(
    parameter int TICK_DIV = 50000,
    parameter int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          run,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next prescaler value and wrap detect.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            tick    = (count_q == LAST_CNT);
            count_d = tick ? '0 : count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with anti-ghost blanking, a
// shadow-buffered load handshake committed on frame boundaries, and leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_digits,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [IW-1:0]           index_q, index_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, act_dp_q, act_dp_d;
    logic                    shadow_lz_q, shadow_lz_d, act_lz_q, act_lz_d;
    logic                    pending_q, pending_d, load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [6:0]              seg_n_q, seg_n_d;
    logic                    dp_n_q, dp_n_d, frame_done_q, frame_done_d;

    logic [CW-1:0]           count_s;
    logic                    tick_s, clear_s, run_s;
    logic                    accept_s, wrap_s, commit_s, zero_run_s;
    logic [3:0]              cur_nib_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;

    assign clear_s = ~enable | (state_q == ST_IDLE);
    assign run_s   = ~clear_s;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .run     (run_s),
        .count   (count_s),
        .tick    (tick_s)
    );

    // Scan FSM: idle -> blank (dark gap) -> show, advancing the digit on each slot tick.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (!enable) begin
            state_d = ST_IDLE;
            index_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    index_d = '0;
                end
                ST_BLANK: begin
                    if (count_s == BLANK_END) state_d = ST_SHOW;
                    else                      state_d = ST_BLANK;
                end
                ST_SHOW: begin
                    if (tick_s) begin
                        state_d = ST_BLANK;
                        index_d = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                end
            endcase
        end
    end

    // Load handshake; the shadow only reaches the active set at a frame boundary or while idle.
    always_comb begin
        accept_s     = load_valid & load_ready_q;
        wrap_s       = enable & (state_q == ST_SHOW) & tick_s & (index_q == LAST_IDX);
        commit_s     = pending_q & (wrap_s | (state_q == ST_IDLE));
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_lz_d  = shadow_lz_q;
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;
        if (accept_s) begin
            shadow_dig_d = load_digits;
            shadow_dp_d  = dp_mask;
            shadow_lz_d  = blank_lz;
        end else begin
            shadow_dig_d = shadow_dig_q;
        end
        if (commit_s) begin
            act_dig_d = shadow_dig_q;
            act_dp_d  = shadow_dp_q;
            act_lz_d  = shadow_lz_q;
        end else begin
            act_dig_d = act_dig_q;
        end
        pending_d    = accept_s | (pending_q & ~commit_s);
        load_ready_d = ~(accept_s | pending_q);
        frame_done_d = wrap_s;
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_mask_s  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run_s   = zero_run_s & (act_dig_q[4*i +: 4] == 4'd0);
            lz_mask_s[i] = zero_run_s & act_lz_q;
        end
    end

    // Display drive, registered one cycle behind the scan state.
    always_comb begin
        cur_nib_s = act_dig_q[{index_q, 2'b00} +: 4];
        an_n_d    = '1;
        seg_n_d   = SEG_OFF;
        dp_n_d    = 1'b1;
        if (state_q == ST_SHOW) begin
            an_n_d[index_q] = 1'b0;
            seg_n_d         = lz_mask_s[index_q] ? SEG_OFF : seg_decode(cur_nib_s);
            dp_n_d          = ~act_dp_q[index_q];
        end else begin
            an_n_d  = '1;
            seg_n_d = SEG_OFF;
            dp_n_d  = 1'b1;
        end
    end

    // State, data and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            shadow_lz_q  <= 1'b0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            an_n_q       <= '1;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_lz_q  <= shadow_lz_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: scripted loads then random traffic, compared each cycle
// against a model that tracks elapsed time within a frame.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * TD;
    localparam int NCYC  = 3000;

    logic             clk = 1'b0;
    logic             reset_n, enable, load_valid, load_ready, blank_lz;
    logic [4*ND-1:0]  load_digits;
    logic [ND-1:0]    dp_mask, an_n;
    logic [6:0]       seg_n;
    logic             dp_n, frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .load_valid(load_valid), .load_ready(load_ready), .load_digits(load_digits),
        .blank_lz(blank_lz), .dp_mask(dp_mask),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
    );

    logic [6:0] seg_tab [16];

    // model state
    bit         m_run, m_act_lz, m_sh_lz, m_pend, m_rdy, m_rise;
    int         m_t;
    logic [3:0] m_act [ND];
    logic [3:0] m_sh  [ND];
    logic [ND-1:0] m_act_dp, m_sh_dp;
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic          e_dp, e_fd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_act_lz = 0; m_sh_lz = 0;
        m_pend = 0; m_rdy = 1; m_rise = 0;
        m_act_dp = '0; m_sh_dp = '0;
        for (int i = 0; i < ND; i++) begin
            m_act[i] = 4'd0;
            m_sh[i]  = 4'd0;
        end
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_step();
        int slot, off, hi;
        bit show, wrap, acc, com;
        slot = m_t / TD;
        off  = m_t % TD;
        show = m_run && (off >= BC);
        hi = -1;
        for (int i = 0; i < ND; i++) if (m_act[i] != 4'd0) hi = i;
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
        if (show) begin
            e_an[slot] = 1'b0;
            e_seg = (m_act_lz && slot > hi && slot != 0) ? 7'h7F : seg_tab[m_act[slot]];
            e_dp  = ~m_act_dp[slot];
        end
        wrap = m_run && enable && (m_t == FRAME - 1);
        e_fd = wrap;
        acc  = load_valid && m_rdy;
        com  = m_pend && (wrap || !m_run);
        if (m_rise) begin m_rdy = 1; m_rise = 0; end
        if (acc) begin
            for (int i = 0; i < ND; i++) m_sh[i] = load_digits[4*i +: 4];
            m_sh_dp = dp_mask; m_sh_lz = blank_lz; m_pend = 1; m_rdy = 0;
        end
        if (com) begin
            for (int i = 0; i < ND; i++) m_act[i] = m_sh[i];
            m_act_dp = m_sh_dp; m_act_lz = m_sh_lz; m_pend = 0; m_rise = 1;
        end
        if (!enable)     begin m_run = 0; m_t = 0; end
        else if (!m_run) begin m_run = 1; m_t = 0; end
        else             m_t = (m_t + 1) % FRAME;
    endtask

    function automatic logic [4*ND-1:0] rand_digits();
        logic [4*ND-1:0] v;
        for (int i = 0; i < ND; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        int off_cnt;
        bit did_rst;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        off_cnt = 0; did_rst = 0;
        reset_n = 1'b0; enable = 1'b0; load_valid = 1'b0;
        load_digits = '0; dp_mask = '0; blank_lz = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_eq("an_n",       an_n,       e_an);
            check_eq("seg_n",      seg_n,      e_seg);
            check_eq("dp_n",       dp_n,       e_dp);
            check_eq("frame_done", frame_done, e_fd);
            check_eq("load_ready", load_ready, m_rdy);
            // asynchronous reset while a digit is lit, between clock edges
            if (!did_rst && cyc > 1500 && e_an != '1) begin
                #1 reset_n = 1'b0;
                #1;
                check_eq("rst_an_n",  an_n,       4'hF);
                check_eq("rst_seg_n", seg_n,      7'h7F);
                check_eq("rst_dp_n",  dp_n,       1'b1);
                check_eq("rst_fd",    frame_done, 1'b0);
                check_eq("rst_ready", load_ready, 1'b1);
                model_reset();
                reset_n = 1'b1;
                did_rst = 1;
            end
            if (cyc < 240) begin
                enable      = (cyc >= 2) && !(cyc >= 220 && cyc < 228);
                load_valid  = (cyc == 0 || cyc == 40 || cyc == 80 || cyc == 150 ||
                               cyc == 200 || cyc == 223);
                blank_lz    = (cyc == 80 || cyc == 150);
                dp_mask     = (cyc == 200) ? 4'b0100 : 4'b0000;
                case (cyc)
                    0:       load_digits = 16'h1234;
                    40:      load_digits = 16'h5678;
                    80:      load_digits = 16'h0007;
                    150:     load_digits = 16'h0000;
                    200:     load_digits = 16'h00A9;
                    223:     load_digits = 16'h9081;
                    default: load_digits = rand_digits();
                endcase
            end else begin
                if (off_cnt > 0) off_cnt--;
                else if ($urandom_range(0, 79) == 0) off_cnt = $urandom_range(1, 6);
                enable      = (off_cnt == 0);
                load_valid  = ($urandom_range(0, 3) == 0);
                load_digits = rand_digits();
                dp_mask     = ND'($urandom_range(0, 15));
                blank_lz    = 1'($urandom_range(0, 1));
            end
            model_step();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits.
REQ-002 SHALL have parameter TICK_DIV, default 50000, clk cycles per digit slot; legal only if TICK_DIV >= BLANK_CYCLES+2.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghost off time at start of each slot.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port enable  in  1  1 = scan display, 0 = display dark.
REQ-007 SHALL have port load_valid  in  1  new digit set offered.
REQ-008 SHALL have port load_ready  out  1  shadow register free.
REQ-009 SHALL have port load_digits  in  4*NUM_DIGITS  BCD nibbles, nibble 0 = rightmost digit.
REQ-010 SHALL have port blank_lz  in  1  leading-zero blanking enable, sampled at commit.
REQ-011 SHALL have port dp_mask  in  NUM_DIGITS  decimal point per digit, sampled with load_digits.
REQ-012 SHALL have port seg_n  out  7  active-low segments, bit6..0 = a,b,c,d,e,f,g.
REQ-013 SHALL have port dp_n  out  1  active-low decimal point.
REQ-014 SHALL have port an_n  out  NUM_DIGITS  active-low digit select, one-hot-low or all ones.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse per completed scan.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap; wrap cycle = slot tick.
REQ-017 FSM states SHALL be IDLE, BLANK, SHOW.
REQ-018 IDLE: enable=1 -> BLANK with digit index 0, prescaler 0; an_n all ones.
REQ-019 BLANK: an_n all ones for BLANK_CYCLES cycles, then SHOW.
REQ-020 SHOW: an_n bit[index] low, seg_n/dp_n show active digit[index]; on slot tick, index increments (wraps NUM_DIGITS-1 -> 0) and state -> BLANK.
REQ-021 enable=0 in any state SHALL force IDLE next cycle; index and prescaler cleared; outputs dark.
REQ-022 All outputs SHALL be registered; an_n/seg_n/dp_n lag state by exactly 1 cycle.
REQ-023 Decode: 0..9 -> 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001101,0000000,0000100; 10..15 -> 1111111 (off).
REQ-024 Handshake: transfer when load_valid & load_ready; load_digits/dp_mask/blank_lz captured into shadow; load_ready drops next cycle.
REQ-025 Shadow SHALL commit to active register on the index wrap NUM_DIGITS-1 -> 0, or next cycle when in IDLE; load_ready rises the cycle after commit.
REQ-026 A frame SHALL never mix old and new digit sets.
REQ-027 frame_done SHALL pulse on the index-wrap cycle, concurrent with any commit; never in IDLE.
REQ-028 Leading-zero blank: with blank_lz=1, digits above the highest nonzero digit show seg_n 1111111; digit 0 never blanked; dp unaffected.
REQ-029 load_valid held while load_ready=0 SHALL be ignored; data not required stable until accept.

Reset
REQ-030 reset_n low SHALL asynchronously set: state IDLE, index 0, prescaler 0, an_n all ones, seg_n 1111111, dp_n 1, frame_done 0, load_ready 1, active and shadow digits 0, pending flag 0, dp mask 0, blank_lz 0.
REQ-031 Reset deassertion mid-frame SHALL restart from IDLE; no partial load retained.

Structure
REQ-032 Shared package SHALL hold the segment pattern constants, SEG_OFF, FSM state enum and decode function.
REQ-033 One sub-module, scan_tick_gen (prescaler + tick), is natural; the rest stays in seg_scan_ctrl.

Verification (TICK_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4)
REQ-034 Reset, enable=1, load 0x1234 -> an_n cycles 1110,1101,1011,0111; seg_n 1001100,0000110,0010010,1001111; an_n 1111 for 2 cycles per slot; frame_done every 32 cycles.
REQ-035 Load 0x5678 mid-frame at index 1 -> display stays 1234 until wrap, then 5678; load_ready 0 until cycle after commit.
REQ-036 blank_lz=1, load 0x0007 -> digits 3..1 seg_n 1111111, digit 0 0001101; load 0x0000 -> digit 0 shows 0000001.
REQ-037 Load 0x00A9 -> digit 1 seg_n 1111111, digit 0 0000100; dp_mask 0100 -> dp_n 0 only while an_n=1011.
REQ-038 enable dropped during SHOW -> next cycle state IDLE, following cycle an_n 1111; load while idle commits, load_ready 0 for 2 cycles.
REQ-039 reset_n pulsed low mid-SHOW, no clock edge -> an_n 1111, seg_n 1111111 immediately; load_ready 1.
